async_receiver: RTL and testbench
=================================

ASYNC_RECEIVER -- requirements
Module: async_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit period.
REQ-004 clk  input  1  system clock (MAX10_CLK1_50 at top level); the block has one clock only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 RxD  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 RxD_data  output  8  last correctly framed byte received.
REQ-008 RxD_data_ready  output  1  one-clk pulse when RxD_data is updated.
REQ-009 RxD_frame_err  output  1  one-clk pulse when a stop bit samples low.
REQ-010 RxD_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 RxD SHALL pass through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-012 The oversample tick SHALL pulse one clk every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clks (integer division; 27 at defaults), free-running from reset.
REQ-013 On each tick, the synchronized RxD SHALL shift into a 3-bit history; the filtered bit is the majority of those 3 bits; history resets to 3'b111.
REQ-014 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; all state transitions occur on tick cycles only.
REQ-015 IDLE: filtered bit 0 on a tick -> START, sample counter cleared to 0.
REQ-016 START: counter increments per tick; at count OVERSAMPLE/2-1 (7), filtered 0 -> DATA with counter cleared, filtered 1 -> IDLE (glitch rejected, no outputs asserted).
REQ-017 DATA: bit sampled when counter reaches OVERSAMPLE-1 (mid-bit), then shifted into the shift register LSB-first, counter cleared; after the 8th bit -> STOP.
REQ-018 STOP: at counter OVERSAMPLE-1, filtered 1 -> RxD_data loaded from the shift register, RxD_data_ready pulses, go to IDLE.
REQ-019 STOP: at counter OVERSAMPLE-1, filtered 0 -> RxD_frame_err pulses, RxD_data is unchanged, go to WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until filtered bit is 1 on a tick, then go to IDLE; this prevents a break condition from generating repeated frames.
REQ-021 RxD_data_ready and RxD_frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one clk per frame.
REQ-022 Latency: RxD_data_ready rises within 9.5 bit periods +/- 3 ticks + 4 clks after the RxD falling edge of the start bit.
REQ-023 A new start bit SHALL be accepted on the first tick after returning to IDLE; back-to-back frames with no idle gap SHALL all be received.

Reset
REQ-024 Assertion of rst_n=0 at any time, including mid-frame, SHALL force: state IDLE, counters 0, tick divider 0, RxD_data 8'h00, RxD_data_ready 0, RxD_frame_err 0, RxD_busy 0; a partial frame is discarded.
REQ-025 After reset release, a line held low SHALL be treated as a start bit only after the history fills with low samples (3 ticks).

Structure
REQ-026 Shared package uart_pkg holds the FSM state encodings, the default CLK_FREQ and BAUD values, and the DIV computation shared with async_transmitter.
REQ-027 A sub-module baud_tick_gen (parameters CLK_FREQ, BAUD, OVERSAMPLE; ports clk, rst_n, tick) SHALL generate the oversample tick.

Verification
REQ-028 Frame 0xA5 at 115200 baud -> RxD_data=8'hA5, a single RxD_data_ready pulse about 82.5 us after the start edge, RxD_frame_err stays 0.
REQ-029 A 2 us low glitch on an idle line -> no ready or error pulse; RxD_busy returns to 0 within 1 bit time.
REQ-030 Frame 0x3C with stop bit forced 0, line held low for 200 us, then released -> one RxD_frame_err pulse; RxD_data keeps its previous value; the next frame 0x42 is received correctly.
REQ-031 Back-to-back frames 0x00, 0xFF, 0x55 with zero idle gap, transmitter at +2% and -2% baud -> three ready pulses with correct data.
REQ-032 rst_n asserted during data bit 4 of a frame, released, then frame 0x81 sent -> outputs are at reset values during reset, no pulse for the aborted frame, 0x81 received.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, default rates and divider math
// Contents:
//   DEFAULT_CLK_FREQ, DEFAULT_BAUD, DEFAULT_OVERSAMPLE : default parameters
//   rx_state_t                                         : receiver FSM encoding
//   calc_div()                                         : clk cycles per oversample tick
package uart_pkg;

   localparam int DEFAULT_CLK_FREQ   = 50_000_000;
   localparam int DEFAULT_BAUD       = 115_200;
   localparam int DEFAULT_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   // Integer division; clamped to 1 so a too-fast baud still yields a tick every clk.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      int d;
      d = clk_freq / (baud * oversample);
      if (d < 1) begin
         d = 1;
      end
      return d;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running oversample tick generator
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (divider cleared to 0)
//   tick  out one-clk pulse every calc_div(CLK_FREQ, BAUD, OVERSAMPLE) clks
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
   parameter int BAUD       = DEFAULT_BAUD,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/async_receiver.sv
// rtl/async_receiver.sv - 8N1 UART receiver with majority-filtered oversampling
// Ports:
//   clk            in  system clock
//   rst_n          in  asynchronous active-low reset
//   RxD            in  asynchronous serial line, idle high, LSB first
//   RxD_data       out last correctly framed byte
//   RxD_data_ready out one-clk pulse when RxD_data is updated
//   RxD_frame_err  out one-clk pulse when the stop bit samples low
//   RxD_busy       out high whenever the FSM is not IDLE
module async_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
   parameter int BAUD       = DEFAULT_BAUD,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_ready,
   output logic       RxD_frame_err,
   output logic       RxD_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   logic            tick;
   logic            rx_meta;
   logic            rx_sync;
   logic [2:0]      hist;
   logic            filt;
   rx_state_t       state;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;

   baud_tick_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Reset to the idle level so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= RxD;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= 3'b111;
      end else if (tick) begin
         hist <= {hist[1:0], rx_sync};
      end
   end

   // Decisions use the history as it stood before this tick's shift, so a line
   // held low is seen as a start bit on the third low tick.
   assign filt = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         bit_idx        <= '0;
         shreg          <= '0;
         RxD_data       <= '0;
         RxD_data_ready <= 1'b0;
         RxD_frame_err  <= 1'b0;
      end else begin
         RxD_data_ready <= 1'b0;
         RxD_frame_err  <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (!filt) begin
                     state <= START;
                     cnt   <= '0;
                  end
               end
               START: begin
                  // Re-check at mid start bit; a high line here was a glitch.
                  if (cnt == MID) begin
                     cnt     <= '0;
                     bit_idx <= '0;
                     state   <= filt ? IDLE : DATA;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               DATA: begin
                  if (cnt == LAST) begin
                     cnt     <= '0;
                     shreg   <= {filt, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) begin
                        state <= STOP;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               STOP: begin
                  if (cnt == LAST) begin
                     cnt <= '0;
                     if (filt) begin
                        RxD_data       <= shreg;
                        RxD_data_ready <= 1'b1;
                        state          <= IDLE;
                     end else begin
                        RxD_frame_err <= 1'b1;
                        state         <= WAIT_HIGH;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               WAIT_HIGH: begin
                  // Hold off until the line idles so a break yields one error only.
                  if (filt) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign RxD_busy = (state != IDLE);

endmodule

// File: tb/tb_async_receiver.sv
// tb/tb_async_receiver.sv - self-checking bench for async_receiver
module tb_async_receiver;

   localparam int BIT_CLKS = 434;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       RxD   = 1'b1;
   logic [7:0] RxD_data;
   logic       RxD_data_ready;
   logic       RxD_frame_err;
   logic       RxD_busy;

   async_receiver dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .RxD            (RxD),
      .RxD_data       (RxD_data),
      .RxD_data_ready (RxD_data_ready),
      .RxD_frame_err  (RxD_frame_err),
      .RxD_busy       (RxD_busy)
   );

   always #10 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed pulses
   int         rdy_cnt      = 0;
   int         err_cnt      = 0;
   int         both_cnt     = 0;
   int         wide_cnt     = 0;
   int         last_rdy_cyc = 0;
   logic       prev_rdy     = 1'b0;
   logic       prev_err     = 1'b0;
   logic [7:0] got_q[$];

   // Reference model: bytes of well-framed frames, count of bad-stop frames
   logic [7:0] exp_q[$];
   int         exp_err   = 0;
   logic [7:0] last_good = 8'h00;

   always @(negedge clk) begin
      if (RxD_data_ready) begin
         rdy_cnt++;
         got_q.push_back(RxD_data);
         last_rdy_cyc = cyc;
      end
      if (RxD_frame_err) err_cnt++;
      if (RxD_data_ready && RxD_frame_err) both_cnt++;
      if ((RxD_data_ready && prev_rdy) || (RxD_frame_err && prev_err)) wide_cnt++;
      prev_rdy = RxD_data_ready;
      prev_err = RxD_frame_err;
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int bc, input logic stop_bit,
                             output int edge_c);
      RxD    = 1'b0;
      edge_c = cyc;
      wclk(bc);
      for (int i = 0; i < 8; i++) begin
         RxD = d[i];
         wclk(bc);
      end
      RxD = stop_bit;
      wclk(bc);
      if (stop_bit) begin
         exp_q.push_back(d);
         last_good = d;
      end else begin
         exp_err++;
      end
   endtask

   task automatic check_stream(input string tag);
      check($sformatf("%s_ready_count", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size())
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      end
      check($sformatf("%s_frame_err_count", tag), err_cnt, exp_err);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int         e;
      int         r0;
      int         e0;
      int         lat;
      int         bc;
      logic [7:0] d;
      logic       sb;
      int         bauds[2];

      bauds[0] = 425;
      bauds[1] = 443;

      // Reset state
      rst_n = 1'b0;
      RxD   = 1'b1;
      wclk(5);
      check("reset_data", RxD_data, 8'h00);
      check("reset_ready", RxD_data_ready, 1'b0);
      check("reset_err", RxD_frame_err, 1'b0);
      check("reset_busy", RxD_busy, 1'b0);
      rst_n = 1'b1;
      wclk(200);
      check("idle_busy", RxD_busy, 1'b0);

      // Nominal frame 0xA5 and its latency from the start edge
      send_frame(8'hA5, BIT_CLKS, 1'b1, e);
      wclk(BIT_CLKS);
      lat = last_rdy_cyc - e;
      check("a5_data", RxD_data, 8'hA5);
      check("a5_latency_in_window", (lat >= 4042 && lat <= 4208), 1'b1);
      check_stream("a5");

      // 2 us glitch on an idle line
      r0 = rdy_cnt;
      e0 = err_cnt;
      RxD = 1'b0;
      wclk(100);
      RxD = 1'b1;
      wclk(BIT_CLKS - 100);
      check("glitch_busy_cleared", RxD_busy, 1'b0);
      wclk(BIT_CLKS);
      check("glitch_no_ready", rdy_cnt - r0, 0);
      check("glitch_no_err", err_cnt - e0, 0);

      // Stop bit low, break held 200 us, then a good frame
      e0 = err_cnt;
      send_frame(8'h3C, BIT_CLKS, 1'b0, e);
      wclk(10000);
      check("break_busy_held", RxD_busy, 1'b1);
      check("break_single_err", err_cnt - e0, 1);
      RxD = 1'b1;
      wclk(2 * BIT_CLKS);
      check("break_busy_released", RxD_busy, 1'b0);
      check("break_data_kept", RxD_data, last_good);
      check_stream("break");
      send_frame(8'h42, BIT_CLKS, 1'b1, e);
      wclk(BIT_CLKS);
      check_stream("after_break");

      // Back-to-back frames at +2% and -2% transmitter baud
      for (int k = 0; k < 2; k++) begin
         send_frame(8'h00, bauds[k], 1'b1, e);
         send_frame(8'hFF, bauds[k], 1'b1, e);
         send_frame(8'h55, bauds[k], 1'b1, e);
         RxD = 1'b1;
         wclk(BIT_CLKS);
         check_stream($sformatf("b2b_%0d", bauds[k]));
      end

      // Randomized frames, random rate within +/-2%, occasional bad stop bit
      for (int k = 0; k < 3; k++) begin
         d  = 8'($urandom_range(0, 255));
         bc = int'($urandom_range(425, 443));
         sb = ($urandom_range(0, 3) != 0);
         send_frame(d, bc, sb, e);
         if (!sb) begin
            wclk(int'($urandom_range(0, 400)));
            RxD = 1'b1;
            wclk(bc);
         end else begin
            wclk(int'($urandom_range(0, 200)));
         end
      end
      wclk(BIT_CLKS);
      check_stream("rand");

      // Reset during data bit 4
      d   = 8'h99;
      RxD = 1'b0;
      wclk(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         RxD = d[i];
         wclk(BIT_CLKS);
      end
      RxD = d[4];
      wclk(BIT_CLKS / 2);
      check("midframe_busy", RxD_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midreset_data", RxD_data, 8'h00);
      check("midreset_ready", RxD_data_ready, 1'b0);
      check("midreset_err", RxD_frame_err, 1'b0);
      check("midreset_busy", RxD_busy, 1'b0);
      wclk(10);
      RxD = 1'b1;
      wclk(10);
      rst_n     = 1'b1;
      last_good = 8'h00;
      wclk(2 * BIT_CLKS);
      check("post_reset_data", RxD_data, last_good);
      send_frame(8'h81, BIT_CLKS, 1'b1, e);
      wclk(BIT_CLKS);
      check("post_reset_81", RxD_data, 8'h81);
      check_stream("after_reset");

      check("never_both_pulses", both_cnt, 0);
      check("pulse_width_one_clk", wide_cnt, 0);

      // Line low across reset release: start accepted only on the third tick
      rst_n = 1'b0;
      RxD   = 1'b0;
      wclk(3);
      rst_n = 1'b1;
      wclk(70);
      check("low_release_two_ticks_idle", RxD_busy, 1'b0);
      wclk(20);
      check("low_release_third_tick_start", RxD_busy, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
